// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the alu controller: FSM states, flag bit positions
// and register-file geometry.
package alu_ctrl_pkg;

    localparam int NREGS  = 4;
    localparam int REG_AW = 2;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_P = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    function automatic logic [3:0] pack_flags(input logic c, input logic n,
                                              input logic p, input logic z);
        logic [3:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_P] = p;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// Operand register file: one write port, two operand read ports and a debug
// read port, all reads combinational; synchronous clear on rst.
module alu_ctrl_regfile
    import alu_ctrl_pkg::*;
#(
    parameter int MAX_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_AW-1:0]    waddr,
    input  logic [MAX_WIDTH-1:0] wdata,
    input  logic [REG_AW-1:0]    ra_addr,
    output logic [MAX_WIDTH-1:0] ra_data,
    input  logic [REG_AW-1:0]    rb_addr,
    output logic [MAX_WIDTH-1:0] rb_data,
    input  logic [REG_AW-1:0]    dbg_addr,
    output logic [MAX_WIDTH-1:0] dbg_data
);

    logic [MAX_WIDTH-1:0] regs_q [NREGS];
    logic [MAX_WIDTH-1:0] regs_d [NREGS];

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign ra_data  = regs_q[ra_addr];
    assign rb_data  = regs_q[rb_addr];
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_ctrl.sv
// Instruction-level initiator for the alu: accepts load/op instructions,
// issues operands for one cycle, captures the result and latches flags.
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int MAX_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic                 instr_ld,
    input  logic [2:0]           instr_op,
    input  logic [1:0]           instr_shamt,
    input  logic [1:0]           instr_rd,
    input  logic [1:0]           instr_ra,
    input  logic [1:0]           instr_rb,
    input  logic [MAX_WIDTH-1:0] instr_imm,
    output logic [2:0]           alu_selop,
    output logic [1:0]           alu_shamt,
    output logic [MAX_WIDTH-1:0] alu_busA,
    output logic [MAX_WIDTH-1:0] alu_busB,
    output logic                 alu_enaf,
    input  logic [MAX_WIDTH-1:0] alu_busC,
    input  logic                 alu_C,
    input  logic                 alu_N,
    input  logic                 alu_P,
    input  logic                 alu_Z,
    output logic [3:0]           flags,
    output logic                 done,
    input  logic [1:0]           dbg_sel,
    output logic [MAX_WIDTH-1:0] dbg_data
);

    // Handshake: an instruction transfers at a rising edge where instr_valid
    // and instr_ready are both 1; the source holds it stable until then.

    state_e               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [1:0]           shamt_q, shamt_d;
    logic [REG_AW-1:0]    rd_q, rd_d;
    logic [MAX_WIDTH-1:0] bus_a_q, bus_a_d;
    logic [MAX_WIDTH-1:0] bus_b_q, bus_b_d;
    logic [3:0]           flags_q, flags_d;
    logic                 done_q, done_d;

    logic                 rf_we;
    logic [REG_AW-1:0]    rf_waddr;
    logic [MAX_WIDTH-1:0] rf_wdata;
    logic [MAX_WIDTH-1:0] rf_a, rf_b;
    logic                 accept;

    alu_ctrl_regfile #(.MAX_WIDTH(MAX_WIDTH)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .ra_addr  (instr_ra),
        .ra_data  (rf_a),
        .rb_addr  (instr_rb),
        .rb_data  (rf_b),
        .dbg_addr (dbg_sel),
        .dbg_data (dbg_data)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        shamt_d     = shamt_q;
        rd_d        = rd_q;
        bus_a_d     = bus_a_q;
        bus_b_d     = bus_b_q;
        flags_d     = flags_q;
        done_d      = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = rd_q;
        rf_wdata    = alu_busC;
        instr_ready = (state_q == ST_IDLE) && !rst;
        accept      = instr_valid && instr_ready;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (instr_ld) begin
                        rf_we    = 1'b1;
                        rf_waddr = instr_rd;
                        rf_wdata = instr_imm;
                        done_d   = 1'b1;
                    end else begin
                        // Operands are sampled at accept; nothing can write the
                        // file before the op's own writeback, so they stay current.
                        state_d = ST_ISSUE;
                        op_d    = instr_op;
                        shamt_d = instr_shamt;
                        rd_d    = instr_rd;
                        bus_a_d = rf_a;
                        bus_b_d = rf_b;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                rf_we   = 1'b1;
                flags_d = pack_flags(alu_C, alu_N, alu_P, alu_Z);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            shamt_q <= '0;
            rd_q    <= '0;
            bus_a_q <= '0;
            bus_b_q <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            shamt_q <= shamt_d;
            rd_q    <= rd_d;
            bus_a_q <= bus_a_d;
            bus_b_q <= bus_b_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    assign alu_selop = op_q;
    assign alu_shamt = shamt_q;
    assign alu_busA  = bus_a_q;
    assign alu_busB  = bus_b_q;
    assign alu_enaf  = (state_q == ST_ISSUE);
    assign flags     = flags_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: registered alu stub, instruction-level register-file
// model, directed scenarios followed by randomized instruction streams.
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid, instr_ready, instr_ld;
    logic [2:0] instr_op;
    logic [1:0] instr_shamt, instr_rd, instr_ra, instr_rb;
    logic [7:0] instr_imm;
    logic [2:0] alu_selop;
    logic [1:0] alu_shamt;
    logic [7:0] alu_busA, alu_busB, alu_busC;
    logic       alu_enaf, alu_C, alu_N, alu_P, alu_Z;
    logic [3:0] flags;
    logic       done;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] m_regs [4];
    logic [3:0] m_flags;

    logic       ovr_en = 1'b0;
    logic [7:0] ovr_c  = '0;
    logic [3:0] ovr_f  = '0;
    logic [3:0] stub_f = '0;

    always #5 clk = ~clk;

    alu_ctrl #(.MAX_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_ld    (instr_ld),
        .instr_op    (instr_op),
        .instr_shamt (instr_shamt),
        .instr_rd    (instr_rd),
        .instr_ra    (instr_ra),
        .instr_rb    (instr_rb),
        .instr_imm   (instr_imm),
        .alu_selop   (alu_selop),
        .alu_shamt   (alu_shamt),
        .alu_busA    (alu_busA),
        .alu_busB    (alu_busB),
        .alu_enaf    (alu_enaf),
        .alu_busC    (alu_busC),
        .alu_C       (alu_C),
        .alu_N       (alu_N),
        .alu_P       (alu_P),
        .alu_Z       (alu_Z),
        .flags       (flags),
        .done        (done),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    // Stand-in alu arithmetic: {result, C, N, P, Z}
    function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op, input logic [1:0] sh);
        logic [8:0] sum;
        logic [7:0] r;
        sum = {1'b0, a} + {1'b0, b >> sh};
        r   = sum[7:0] ^ {5'd0, op};
        return {r, sum[8], r[7], ^r, (r == 8'd0)};
    endfunction

    initial alu_busC = '0;
    always @(posedge clk) begin
        if (alu_enaf) begin
            if (ovr_en) {alu_busC, stub_f} <= {ovr_c, ovr_f};
            else        {alu_busC, stub_f} <= alu_fn(alu_busA, alu_busB, alu_selop, alu_shamt);
        end
    end
    assign {alu_C, alu_N, alu_P, alu_Z} = stub_f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input int r);
        dbg_sel = r[1:0];
        #1;
        chk(tag, {24'd0, dbg_data}, {24'd0, m_regs[r]});
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_flags = '0;
    endtask

    // Presents a load, takes the accepting edge; valid is left asserted.
    task automatic do_load(input logic [1:0] rd, input logic [7:0] imm);
        instr_valid = 1'b1;
        instr_ld    = 1'b1;
        instr_rd    = rd;
        instr_imm   = imm;
        instr_op    = 3'($urandom_range(0, 7));
        chk("ld_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        m_regs[rd] = imm;
        chk("ld_done", {31'd0, done}, 32'd1);
        chk("ld_flags_kept", {28'd0, flags}, {28'd0, m_flags});
        chk_reg("ld_reg", rd);
    endtask

    // Runs one operation through ISSUE/CAPTURE and returns at #1 after t2.
    // With hold set, a pending load (hold_rd/hold_imm) is presented from t0 on.
    task automatic do_op(input logic [2:0] op, input logic [1:0] sh, input logic [1:0] rd,
                         input logic [1:0] ra, input logic [1:0] rb,
                         input bit hold, input logic [1:0] hold_rd, input logic [7:0] hold_imm);
        logic [11:0] exp;
        exp = ovr_en ? {ovr_c, ovr_f} : alu_fn(m_regs[ra], m_regs[rb], op, sh);
        instr_valid = 1'b1;
        instr_ld    = 1'b0;
        instr_op    = op;
        instr_shamt = sh;
        instr_rd    = rd;
        instr_ra    = ra;
        instr_rb    = rb;
        instr_imm   = 8'($urandom);
        chk("op_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        if (hold) begin
            instr_ld  = 1'b1;
            instr_rd  = hold_rd;
            instr_imm = hold_imm;
        end else begin
            instr_valid = 1'b0;
        end
        chk("iss_enaf", {31'd0, alu_enaf}, 32'd1);
        chk("iss_ready", {31'd0, instr_ready}, 32'd0);
        chk("iss_done", {31'd0, done}, 32'd0);
        chk("iss_busA", {24'd0, alu_busA}, {24'd0, m_regs[ra]});
        chk("iss_busB", {24'd0, alu_busB}, {24'd0, m_regs[rb]});
        chk("iss_selop", {29'd0, alu_selop}, {29'd0, op});
        chk("iss_shamt", {30'd0, alu_shamt}, {30'd0, sh});
        tick();
        chk("cap_enaf", {31'd0, alu_enaf}, 32'd0);
        chk("cap_ready", {31'd0, instr_ready}, 32'd0);
        chk("cap_busA", {24'd0, alu_busA}, {24'd0, m_regs[ra]});
        chk("cap_busB", {24'd0, alu_busB}, {24'd0, m_regs[rb]});
        chk("cap_selop", {29'd0, alu_selop}, {29'd0, op});
        if (hold) chk_reg("cap_hold_reg", hold_rd);
        tick();
        m_regs[rd] = exp[11:4];
        m_flags    = exp[3:0];
        chk("wb_done", {31'd0, done}, 32'd1);
        chk("wb_flags", {28'd0, flags}, {28'd0, m_flags});
        chk("wb_enaf", {31'd0, alu_enaf}, 32'd0);
        chk("wb_ready", {31'd0, instr_ready}, 32'd1);
        chk_reg("wb_reg", rd);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {31'd0, instr_ready}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_flags"}, {28'd0, flags}, 32'd0);
        chk({tag, "_enaf"}, {31'd0, alu_enaf}, 32'd0);
        chk({tag, "_selop"}, {29'd0, alu_selop}, 32'd0);
        chk({tag, "_shamt"}, {30'd0, alu_shamt}, 32'd0);
        chk({tag, "_busA"}, {24'd0, alu_busA}, 32'd0);
        chk({tag, "_busB"}, {24'd0, alu_busB}, 32'd0);
        for (int r = 0; r < 4; r++) chk_reg({tag, "_reg"}, r);
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0; instr_ld = 1'b0; instr_op = '0; instr_shamt = '0;
        instr_rd = '0; instr_ra = '0; instr_rb = '0; instr_imm = '0; dbg_sel = '0;
        model_clear();
        tick();
        tick();
        chk_all_zero("rst");
        rst = 1'b0;
        #1;

        // Back-to-back loads
        do_load(2'd0, 8'h26);
        do_load(2'd1, 8'hFF);
        instr_valid = 1'b0;
        tick();
        chk("ld_pulse_end", {31'd0, done}, 32'd0);
        chk_reg("ld_r0", 0);
        chk_reg("ld_r1", 1);

        // Directed op with fixed stub response
        ovr_en = 1'b1; ovr_c = 8'hA5; ovr_f = 4'b0101;
        do_op(3'b101, 2'b00, 2'd2, 2'd0, 2'd1, 1'b0, 2'd0, 8'h00);
        ovr_en = 1'b0;
        chk("op_r2", {24'd0, m_regs[2]}, 32'hA5);
        tick();
        chk("op_pulse_end", {31'd0, done}, 32'd0);

        // rd == ra == rb, then a consumer of the new value
        do_load(2'd2, 8'hEB);
        instr_valid = 1'b0;
        tick();
        do_op(3'($urandom_range(0, 7)), 2'b11, 2'd2, 2'd2, 2'd2, 1'b0, 2'd0, 8'h00);
        do_op(3'($urandom_range(0, 7)), 2'b01, 2'd0, 2'd2, 2'd2, 1'b0, 2'd0, 8'h00);

        // Backpressure: a load waits through ISSUE/CAPTURE, runs once
        do_op(3'd3, 2'd1, 2'd3, 2'd0, 2'd1, 1'b1, 2'd1, 8'h5A);
        tick();
        instr_valid = 1'b0;
        m_regs[1] = 8'h5A;
        chk("bp_done", {31'd0, done}, 32'd1);
        chk_reg("bp_reg", 1);
        tick();
        chk("bp_once", {31'd0, done}, 32'd0);

        // Reset during ISSUE
        instr_valid = 1'b1; instr_ld = 1'b0; instr_op = 3'd6; instr_rd = 2'd0;
        instr_ra = 2'd1; instr_rb = 2'd2; instr_shamt = 2'd2;
        tick();
        instr_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_iss_ready", {31'd0, instr_ready}, 32'd0);
        tick();
        tick();
        model_clear();
        chk_all_zero("rst_iss");
        rst = 1'b0;
        tick();
        chk("rst_iss_nodone", {31'd0, done}, 32'd0);

        // Reset during CAPTURE with rd=3 holding 8'h11
        do_load(2'd3, 8'h11);
        instr_valid = 1'b0;
        tick();
        ovr_en = 1'b1; ovr_c = 8'h77; ovr_f = 4'b1111;
        do_op(3'd0, 2'd0, 2'd1, 2'd3, 2'd3, 1'b0, 2'd0, 8'h00);
        ovr_en = 1'b0;
        chk("pre_rst_flags", {28'd0, flags}, 32'hF);
        instr_valid = 1'b1; instr_ld = 1'b0; instr_rd = 2'd3; instr_ra = 2'd1; instr_rb = 2'd0;
        tick();
        instr_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        model_clear();
        chk("rst_cap_done", {31'd0, done}, 32'd0);
        chk("rst_cap_flags", {28'd0, flags}, 32'd0);
        chk_reg("rst_cap_r3", 3);
        rst = 1'b0;
        tick();
        chk("rst_cap_nodone", {31'd0, done}, 32'd0);
        do_load(2'd3, 8'h11);
        instr_valid = 1'b0;
        tick();

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_load(2'($urandom_range(0, 3)), 8'($urandom));
            end else begin
                do_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 1'b0, 2'd0, 8'h00);
            end
            if ($urandom_range(0, 1) == 1) begin
                instr_valid = 1'b0;
                tick();
                chk("rnd_gap_done", {31'd0, done}, 32'd0);
            end
        end
        instr_valid = 1'b0;
        tick();
        for (int r = 0; r < 4; r++) chk_reg("final_reg", r);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
